vebpf_mem_initiator: RTL and testbench

Load/store initiator that issues byte-serial data-memory transactions on the team's stb/ack scratch-RAM bus on behalf of the VeBPF core. It accepts one core-side request at a time: byte, half, word or double-word; load or store. It drives the RAM handshake and width code, then returns width-selected, zero-extended load data. It also flags out-of-range and timed-out accesses.

---
 rtl/vebpf_mem_initiator.sv | 223 ++++++++++++++++++++++
 tb/tb_vebpf_mem_initiator.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vebpf_mem_initiator.sv
// ============================================================================
// vebpf_mem_initiator
// ----------------------------------------------------------------------------
// Load/store initiator for the VeBPF core. Takes one core request at a time
// (byte, half, word or double-word; load or store), runs a single strobe/ack
// cycle on the scratch-RAM bus, and returns a one-cycle response carrying
// zero-extended load data or an error flag. Accesses that would run past the
// end of memory are rejected without touching the bus. A strobe left
// unanswered for TIMEOUT_CYCLES cycles is abandoned and reported as an error.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   core request handshake (accepted when both high)
//   req_we            1 = store, 0 = load
//   req_size          0=byte, 1=half, 2=word, 3=double-word
//   req_addr          byte address of the lowest byte (little-endian)
//   req_wdata         store data, low bytes used
//   rsp_valid         one-cycle completion pulse
//   rsp_err           range error or timeout, qualifies rsp_valid
//   rsp_rdata         load result, zero-extended; 0 for stores and errors
//   mem_adr/stb/we    RAM address, strobe, write enable
//   mem_ww            RAM byte count 1/2/4/8
//   mem_dat_w         RAM write data, bytes above the access width zeroed
//   mem_ack           RAM acknowledge
//   mem_dat_r0..r8    RAM read lanes of 8/16/32/64 bits
// ============================================================================
module vebpf_mem_initiator #(
    parameter int DATA_SIZE      = 64,
    parameter int ADDRESS_SIZE   = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [1:0]              req_size,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0]    req_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_err,
    output logic [DATA_SIZE-1:0]    rsp_rdata,
    output logic [ADDRESS_SIZE-1:0] mem_adr,
    output logic                    mem_stb,
    output logic                    mem_we,
    output logic [3:0]              mem_ww,
    output logic [DATA_SIZE-1:0]    mem_dat_w,
    input  logic                    mem_ack,
    input  logic [7:0]              mem_dat_r0,
    input  logic [15:0]             mem_dat_r2,
    input  logic [31:0]             mem_dat_r4,
    input  logic [63:0]             mem_dat_r8
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE,
        RESP
    } state_t;

    // The strobe is dropped on the edge where the counter holds this value,
    // which leaves it high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0]            TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDRESS_SIZE:0] MEM_SPAN     = {1'b1, {ADDRESS_SIZE{1'b0}}};
    localparam logic [ADDRESS_SIZE:0] ONE_EXT      = {{ADDRESS_SIZE{1'b0}}, 1'b1};

    state_t                  state, state_nxt;
    logic [7:0]              cnt, cnt_nxt;
    logic [1:0]              size_q, size_nxt;
    logic                    ready_nxt;
    logic                    stb_nxt;
    logic                    we_nxt;
    logic [3:0]              ww_nxt;
    logic [ADDRESS_SIZE-1:0] adr_nxt;
    logic [DATA_SIZE-1:0]    dat_w_nxt;
    logic                    rsp_valid_nxt;
    logic                    rsp_err_nxt;
    logic [DATA_SIZE-1:0]    rsp_rdata_nxt;

    logic [ADDRESS_SIZE:0]   end_addr;
    logic                    range_err;
    logic [DATA_SIZE-1:0]    wdata_masked;
    logic [DATA_SIZE-1:0]    rd_lane;

    // One extra bit so an access ending exactly at the top of memory is
    // distinguished from one that would wrap back to address zero.
    assign end_addr  = {1'b0, req_addr} + (ONE_EXT << req_size);
    assign range_err = end_addr > MEM_SPAN;

    // Store data with every byte beyond the access width forced to zero.
    always_comb begin
        wdata_masked = '0;
        unique case (req_size)
            2'd0:    wdata_masked = DATA_SIZE'(req_wdata[7:0]);
            2'd1:    wdata_masked = DATA_SIZE'(req_wdata[15:0]);
            2'd2:    wdata_masked = DATA_SIZE'(req_wdata[31:0]);
            default: wdata_masked = req_wdata;
        endcase
    end

    // Read lane matching the size of the transaction in flight.
    always_comb begin
        rd_lane = '0;
        unique case (size_q)
            2'd0:    rd_lane = DATA_SIZE'(mem_dat_r0);
            2'd1:    rd_lane = DATA_SIZE'(mem_dat_r2);
            2'd2:    rd_lane = DATA_SIZE'(mem_dat_r4);
            default: rd_lane = DATA_SIZE'(mem_dat_r8);
        endcase
    end

    // Next-state and next-output logic. Every output is a register, so this
    // block computes the value each output takes after the coming edge.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        size_nxt      = size_q;
        ready_nxt     = req_ready;
        stb_nxt       = mem_stb;
        we_nxt        = mem_we;
        ww_nxt        = mem_ww;
        adr_nxt       = mem_adr;
        dat_w_nxt     = mem_dat_w;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = rsp_err;
        rsp_rdata_nxt = rsp_rdata;

        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    ready_nxt = 1'b0;
                    size_nxt  = req_size;
                    we_nxt    = req_we;
                    ww_nxt    = 4'd1 << req_size;
                    adr_nxt   = req_addr;
                    dat_w_nxt = wdata_masked;
                    cnt_nxt   = '0;
                    if (range_err) begin
                        state_nxt     = RESP;
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_rdata_nxt = '0;
                    end else begin
                        state_nxt = ACCESS;
                        stb_nxt   = 1'b1;
                    end
                end
            end

            // An ack seen on the timeout edge still counts as success.
            ACCESS: begin
                if (mem_ack) begin
                    state_nxt     = RESP;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = mem_we ? '0 : rd_lane;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt     = RESP;
                    stb_nxt       = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end

            RESP: begin
                state_nxt     = RELEASE;
                rsp_err_nxt   = 1'b0;
                rsp_rdata_nxt = '0;
            end

            // Hold off the next strobe until the RAM has retired its ack.
            RELEASE: begin
                if (!mem_ack) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any transaction in flight
    // without producing a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            size_q    <= '0;
            req_ready <= 1'b0;
            mem_stb   <= 1'b0;
            mem_we    <= 1'b0;
            mem_ww    <= '0;
            mem_adr   <= '0;
            mem_dat_w <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            size_q    <= size_nxt;
            req_ready <= ready_nxt;
            mem_stb   <= stb_nxt;
            mem_we    <= we_nxt;
            mem_ww    <= ww_nxt;
            mem_adr   <= adr_nxt;
            mem_dat_w <= dat_w_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_vebpf_mem_initiator.sv
// ============================================================================
// tb_vebpf_mem_initiator
// ----------------------------------------------------------------------------
// Bench for vebpf_mem_initiator with a scratch-RAM responder model. Expected
// results come from a byte-array image of memory updated per request.
// ============================================================================
module tb_vebpf_mem_initiator;

    localparam int AW       = 11;
    localparam int DW       = 64;
    localparam int TMO      = 12;
    localparam int SPAN     = 2048;
    localparam int LOAD_LAT = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] mem_adr;
    logic          mem_stb;
    logic          mem_we;
    logic [3:0]    mem_ww;
    logic [DW-1:0] mem_dat_w;
    logic          mem_ack = 1'b0;
    logic [7:0]    mem_dat_r0;
    logic [15:0]   mem_dat_r2;
    logic [31:0]   mem_dat_r4;
    logic [63:0]   mem_dat_r8;

    int checks   = 0;
    int failures = 0;

    // Responder knobs: neverAck models a dead slave, overrideLat forces the
    // number of strobe cycles the RAM counts before raising ack.
    logic neverAck    = 1'b0;
    int   overrideLat = 0;
    int   holdCnt     = 0;
    int   curLat;

    logic [7:0]  ram   [0:SPAN-1] = '{default: 8'h00};
    logic [7:0]  model [0:SPAN-1] = '{default: 8'h00};
    logic [63:0] rdBytes;

    vebpf_mem_initiator #(
        .DATA_SIZE      (DW),
        .ADDRESS_SIZE   (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_adr    (mem_adr),
        .mem_stb    (mem_stb),
        .mem_we     (mem_we),
        .mem_ww     (mem_ww),
        .mem_dat_w  (mem_dat_w),
        .mem_ack    (mem_ack),
        .mem_dat_r0 (mem_dat_r0),
        .mem_dat_r2 (mem_dat_r2),
        .mem_dat_r4 (mem_dat_r4),
        .mem_dat_r8 (mem_dat_r8)
    );

    always #5 clk = ~clk;

    // Scratch-RAM: stores ack ww cycles into the strobe, loads after
    // LOAD_LAT; ack holds while stb is high and clears the cycle after.
    always_comb curLat = (overrideLat != 0) ? overrideLat : (mem_we ? int'(mem_ww) : LOAD_LAT);

    always @(posedge clk) begin
        if (mem_stb) begin
            holdCnt <= holdCnt + 1;
            if (!neverAck && !mem_ack && (holdCnt + 1 >= curLat)) begin
                mem_ack <= 1'b1;
                if (mem_we) begin
                    for (int b = 0; b < 8; b++) begin
                        if (b < int'(mem_ww)) ram[mem_adr + 11'(b)] <= mem_dat_w[8*b +: 8];
                    end
                end
            end
        end else begin
            holdCnt <= 0;
            mem_ack <= 1'b0;
        end
    end

    always_comb begin
        rdBytes = '0;
        for (int b = 0; b < 8; b++) rdBytes[8*b +: 8] = ram[mem_adr + 11'(b)];
    end

    assign mem_dat_r0 = rdBytes[7:0];
    assign mem_dat_r2 = rdBytes[15:0];
    assign mem_dat_r4 = rdBytes[31:0];
    assign mem_dat_r8 = rdBytes;

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] modelRead(input int a, input int n);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < n; b++) r[8*b +: 8] = model[a + b];
        return r;
    endfunction

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"}, req_ready, 0);
        checkOutput({tag, " mem_stb"},   mem_stb,   0);
        checkOutput({tag, " mem_we"},    mem_we,    0);
        checkOutput({tag, " mem_ww"},    mem_ww,    0);
        checkOutput({tag, " mem_adr"},   mem_adr,   0);
        checkOutput({tag, " mem_dat_w"}, mem_dat_w, 0);
        checkOutput({tag, " rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, " rsp_err"},   rsp_err,   0);
        checkOutput({tag, " rsp_rdata"}, rsp_rdata, 0);
    endtask

    task automatic waitReady(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) checkOutput({tag, " ready wait"}, req_ready, 1);
    endtask

    // One complete request: issue, observe bus and response, compare.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic [AW-1:0] addr, input logic [63:0] wdata);
        int          nbytes, lat, stbCycles, rspAt;
        bit          rangeErr, timedOut, sawStb;
        logic [63:0] expRdata, expDatW, gotRdata, gotDatW;
        logic        gotErr, gotWe;
        logic [3:0]  gotWw;
        logic [AW-1:0] gotAdr;

        nbytes   = 1 << size;
        rangeErr = (int'(addr) + nbytes) > SPAN;
        lat      = (overrideLat != 0) ? overrideLat : (we ? nbytes : LOAD_LAT);
        timedOut = !rangeErr && (neverAck || lat >= TMO);
        expDatW  = (nbytes == 8) ? wdata : (wdata & ((64'd1 << (8 * nbytes)) - 64'd1));
        expRdata = (we || rangeErr || timedOut) ? 64'd0 : modelRead(int'(addr), nbytes);

        waitReady(tag);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput({tag, " ready low"}, req_ready, 0);

        stbCycles = 0;
        rspAt     = 0;
        sawStb    = 0;
        gotErr    = 1'bx;
        gotRdata  = 'x;
        gotDatW   = 'x;
        gotWe     = 1'bx;
        gotWw     = 'x;
        gotAdr    = 'x;
        for (int k = 1; k <= 150 && rspAt == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_stb) begin
                if (!sawStb) begin
                    gotAdr  = mem_adr;
                    gotWe   = mem_we;
                    gotWw   = mem_ww;
                    gotDatW = mem_dat_w;
                end
                sawStb = 1;
                stbCycles++;
            end
            if (rsp_valid) begin
                rspAt    = k;
                gotErr   = rsp_err;
                gotRdata = rsp_rdata;
            end
        end

        if (rangeErr) begin
            checkOutput({tag, " stb cycles"}, stbCycles, 0);
            checkOutput({tag, " rsp cycle"},  rspAt,     1);
        end else if (timedOut) begin
            checkOutput({tag, " stb cycles"}, stbCycles, TMO);
            checkOutput({tag, " rsp cycle"},  rspAt,     TMO + 1);
        end else begin
            checkOutput({tag, " stb cycles"}, stbCycles, lat + 1);
            checkOutput({tag, " rsp cycle"},  rspAt,     lat + 2);
        end
        if (sawStb) begin
            checkOutput({tag, " mem_adr"},   gotAdr,  addr);
            checkOutput({tag, " mem_we"},    gotWe,   we);
            checkOutput({tag, " mem_ww"},    gotWw,   nbytes);
            checkOutput({tag, " mem_dat_w"}, gotDatW, expDatW);
        end
        checkOutput({tag, " rsp_err"},   gotErr,   rangeErr || timedOut);
        checkOutput({tag, " rsp_rdata"}, gotRdata, expRdata);

        @(negedge clk);
        checkOutput({tag, " single pulse"}, rsp_valid, 0);

        if (we && !rangeErr && !timedOut) begin
            for (int b = 0; b < nbytes; b++) model[int'(addr) + b] = wdata[8*b +: 8];
        end
    endtask

    initial begin
        int accepts, rises, pulses;
        bit dropPending, gapSeen, prevStb;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready after reset", req_ready, 1);

        $display("[TB] directed store/load sequence");
        applyStimulus("st DW 010", 1'b1, 2'd3, 11'h010, 64'h1122334455667788);
        applyStimulus("ld DW 010", 1'b0, 2'd3, 11'h010, 64'h0);
        applyStimulus("st B 013",  1'b1, 2'd0, 11'h013, 64'hFFFFFFFFFFFFFFAB);
        applyStimulus("ld H 012",  1'b0, 2'd1, 11'h012, 64'h0);
        checkOutput("model H 012", modelRead(12'h012, 2), 64'hAB66);
        applyStimulus("ld B 013",  1'b0, 2'd0, 11'h013, 64'h0);
        applyStimulus("st W 021",  1'b1, 2'd2, 11'h021, 64'hCAFEF00D87654321);
        applyStimulus("ld DW 020", 1'b0, 2'd3, 11'h020, 64'h0);

        $display("[TB] range boundaries");
        applyStimulus("ld W 7FE",  1'b0, 2'd2, 11'h7FE, 64'h0);
        applyStimulus("ld W 7FC",  1'b0, 2'd2, 11'h7FC, 64'h0);
        applyStimulus("st DW 7F8", 1'b1, 2'd3, 11'h7F8, 64'h0102030405060708);
        applyStimulus("ld DW 7F8", 1'b0, 2'd3, 11'h7F8, 64'h0);
        applyStimulus("ld B 7FF",  1'b0, 2'd0, 11'h7FF, 64'h0);
        applyStimulus("st H 7FF",  1'b1, 2'd1, 11'h7FF, 64'h5555);

        $display("[TB] timeout behaviour");
        neverAck = 1'b1;
        applyStimulus("no-ack ld W", 1'b0, 2'd2, 11'h100, 64'h0);
        neverAck = 1'b0;
        applyStimulus("after timeout", 1'b0, 2'd3, 11'h010, 64'h0);
        overrideLat = TMO - 1;
        applyStimulus("ack on last cycle", 1'b0, 2'd3, 11'h010, 64'h0);
        overrideLat = TMO;
        applyStimulus("ack one too late", 1'b0, 2'd3, 11'h010, 64'h0);
        overrideLat = 0;

        $display("[TB] back-to-back loads with valid held");
        waitReady("b2b");
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_size    = 2'd3;
        req_addr    = 11'h010;
        accepts     = 0;
        rises       = 0;
        pulses      = 0;
        dropPending = 0;
        gapSeen     = 0;
        prevStb     = mem_stb;
        for (int k = 0; k < 300 && !(pulses == 3 && !req_valid && k > 0 && !mem_stb && accepts == 3 && rsp_valid == 1'b0 && rises == 3 && k > 60); k++) begin
            if (dropPending) begin
                req_valid   = 1'b0;
                dropPending = 0;
            end
            if (req_valid && req_ready) begin
                accepts++;
                if (accepts == 3) dropPending = 1;
            end
            if (mem_stb && !prevStb) begin
                if (rises > 0) checkOutput("b2b idle gap", gapSeen, 1);
                rises++;
                gapSeen = 0;
            end
            if (!mem_stb && !mem_ack) gapSeen = 1;
            if (rsp_valid) begin
                pulses++;
                checkOutput("b2b rsp_err",   rsp_err,   0);
                checkOutput("b2b rsp_rdata", rsp_rdata, modelRead(16'h010, 8));
            end
            prevStb = mem_stb;
            @(negedge clk);
        end
        checkOutput("b2b accepts",  accepts, 3);
        checkOutput("b2b stb rises", rises,  3);
        checkOutput("b2b pulses",   pulses,  3);
        req_valid = 1'b0;

        $display("[TB] reset during access");
        waitReady("rst-mid");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd3;
        req_addr  = 11'h040;
        req_wdata = 64'hDEADBEEF0BADF00D;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rst-mid stb up", mem_stb, 1);
        repeat (3) @(negedge clk);
        checkOutput("rst-mid in access", mem_stb, 1);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("rst-mid");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst-mid ready", req_ready, 1);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid || mem_stb) pulses++;
            @(negedge clk);
        end
        checkOutput("rst-mid quiet bus", pulses, 0);
        applyStimulus("post-rst ld DW 040", 1'b0, 2'd3, 11'h040, 64'h0);
        applyStimulus("post-rst st W 040",  1'b1, 2'd2, 11'h040, 64'h0000000076543210);
        applyStimulus("post-rst ld DW 040", 1'b0, 2'd3, 11'h040, 64'h0);

        $display("[TB] randomized requests");
        for (int n = 0; n < 40; n++) begin
            logic          rWe;
            logic [1:0]    rSize;
            logic [AW-1:0] rAddr;
            logic [63:0]   rData;
            rWe   = 1'($urandom_range(0, 1));
            rSize = 2'($urandom_range(0, 3));
            rAddr = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 63)) : 11'($urandom_range(2040, 2047));
            rData = {$urandom, $urandom};
            applyStimulus($sformatf("rand%0d", n), rWe, rSize, rAddr, rData);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
